block_packer: RTL and testbench

BLOCK_PACKER -- requirements
Module: block_packer

---
 rtl/crypto_pkg.sv | 10 +
 rtl/block_pad_fill.sv | 31 +++
 rtl/block_packer.sv | 111 +++++++++++
 tb/tb_block_packer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/crypto_pkg.sv
// Shared block/byte types and sizing constants for the packer datapath.
package crypto_pkg;

  localparam int BYTES_PER_BLOCK = 4;
  localparam int BYTE_WIDTH      = 8;

  typedef logic [31:0] block_t;
  typedef logic [1:0]  byte_idx_t;

endpackage

// File: rtl/block_pad_fill.sv
// Combinational lane filler: pads the lanes after the last byte with the pad count.
// Zero latency; no flow control of its own.
module block_pad_fill
  import crypto_pkg::*;
(
  input  block_t    acc,
  input  byte_idx_t idx,
  input  logic      last,
  output block_t    block,
  output logic [1:0] pad_cnt
);

  logic [BYTE_WIDTH-1:0] pad_val;

  // idx is the lane of the byte just merged into acc, so 3-idx lanes remain.
  assign pad_cnt = last ? (2'd3 - idx) : 2'd0;
  assign pad_val = {6'd0, pad_cnt};

  always_comb begin
    block = acc;
    if (last) begin
      unique case (idx)
        2'd0:    block = {acc[31:24], pad_val, pad_val, pad_val};
        2'd1:    block = {acc[31:16], pad_val, pad_val};
        2'd2:    block = {acc[31:8], pad_val};
        default: block = acc;
      endcase
    end
  end

endmodule

// File: rtl/block_packer.sv
// Packs bytes big-endian into 32-bit blocks; block valid 1 cycle after completing byte.
// Stalls input while a block waits for downstream; stats counters under BLOCK_PACKER_STATS_EN.
module block_packer
  import crypto_pkg::*;
#(
  parameter int BLOCK_WIDTH   = 32,
  parameter int COUNTER_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               byte_in,
  input  logic                     byte_in_valid,
  input  logic                     byte_in_last,
  output logic                     byte_in_ready,
  output logic [BLOCK_WIDTH-1:0]   block_out,
  output logic                     block_out_valid,
  output logic                     block_out_last,
  input  logic                     block_out_ready,
  output logic [COUNTER_WIDTH-1:0] bytes_accepted,
  output logic [COUNTER_WIDTH-1:0] blocks_emitted,
  output logic [COUNTER_WIDTH-1:0] pad_bytes
);

  byte_idx_t  idx;
  block_t     acc;
  block_t     merged;
  block_t     padded;
  logic [1:0] pad_cnt;
  logic       byte_xfer;
  logic       block_xfer;
  logic       complete;

  assign byte_in_ready = !block_out_valid || block_out_ready;
  assign byte_xfer     = byte_in_valid && byte_in_ready;
  assign block_xfer    = block_out_valid && block_out_ready;
  assign complete      = byte_xfer && ((idx == 2'd3) || byte_in_last);

  always_comb begin
    merged = acc;
    unique case (idx)
      2'd0:    merged[31:24] = byte_in;
      2'd1:    merged[23:16] = byte_in;
      2'd2:    merged[15:8]  = byte_in;
      default: merged[7:0]   = byte_in;
    endcase
  end

  block_pad_fill u_pad_fill (
    .acc     (merged),
    .idx     (idx),
    .last    (byte_in_last),
    .block   (padded),
    .pad_cnt (pad_cnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx             <= '0;
      acc             <= '0;
      block_out       <= '0;
      block_out_valid <= 1'b0;
      block_out_last  <= 1'b0;
    end else begin
      if (complete) begin
        // Completion wins over a same-cycle handoff so the output never bubbles.
        block_out       <= padded;
        block_out_valid <= 1'b1;
        block_out_last  <= byte_in_last;
        idx             <= '0;
        acc             <= '0;
      end else begin
        if (byte_xfer) begin
          acc <= merged;
          idx <= idx + 2'd1;
        end
        if (block_xfer) begin
          block_out_valid <= 1'b0;
        end
      end
    end
  end

`ifdef BLOCK_PACKER_STATS_EN
  logic [COUNTER_WIDTH-1:0] bytes_q;
  logic [COUNTER_WIDTH-1:0] blocks_q;
  logic [COUNTER_WIDTH-1:0] pads_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bytes_q  <= '0;
      blocks_q <= '0;
      pads_q   <= '0;
    end else begin
      if (byte_xfer)  bytes_q  <= bytes_q + COUNTER_WIDTH'(1);
      if (block_xfer) blocks_q <= blocks_q + COUNTER_WIDTH'(1);
      if (complete)   pads_q   <= pads_q + COUNTER_WIDTH'(pad_cnt);
    end
  end

  assign bytes_accepted = bytes_q;
  assign blocks_emitted = blocks_q;
  assign pad_bytes      = pads_q;
`else
  logic pad_cnt_unused;
  assign pad_cnt_unused = ^pad_cnt;
  assign bytes_accepted = '0;
  assign blocks_emitted = '0;
  assign pad_bytes      = '0;
`endif

endmodule

// File: tb/tb_block_packer.sv
// Self-checking bench for block_packer: directed cases plus randomized messages vs. a byte-queue model.
module tb_block_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  byte_in;
  logic        byte_in_valid;
  logic        byte_in_last;
  logic        byte_in_ready;
  logic [31:0] block_out;
  logic        block_out_valid;
  logic        block_out_last;
  logic        block_out_ready;
  logic [31:0] bytes_accepted;
  logic [31:0] blocks_emitted;
  logic [31:0] pad_bytes;

  block_packer #(.BLOCK_WIDTH(32), .COUNTER_WIDTH(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .byte_in         (byte_in),
    .byte_in_valid   (byte_in_valid),
    .byte_in_last    (byte_in_last),
    .byte_in_ready   (byte_in_ready),
    .block_out       (block_out),
    .block_out_valid (block_out_valid),
    .block_out_last  (block_out_last),
    .block_out_ready (block_out_ready),
    .bytes_accepted  (bytes_accepted),
    .blocks_emitted  (blocks_emitted),
    .pad_bytes       (pad_bytes)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: bytes of the open message chunk, and the expected block stream.
  logic [7:0]  cur_q[$];
  logic [31:0] exp_blk_q[$];
  logic        exp_last_q[$];
  int m_bytes, m_blocks, m_pads;

  int ready_pct = 100;
  int stall_cnt = 0;
  logic        held_vld = 1'b0;
  logic [31:0] held_blk;
  logic        held_last;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_accept(input logic [7:0] b, input logic l);
    logic [31:0] blk;
    int n;
    cur_q.push_back(b);
    m_bytes++;
    if (cur_q.size() == 4 || l) begin
      n = cur_q.size();
      blk = 32'd0;
      for (int i = 0; i < 4; i++)
        blk = {blk[23:0], (i < n) ? cur_q[i] : 8'(4 - n)};
      exp_blk_q.push_back(blk);
      exp_last_q.push_back(l);
      m_pads += 4 - n;
      cur_q.delete();
    end
  endtask

  // One clock: drive at the falling edge, sample 1 time unit later, advance to the next falling edge.
  task automatic cycle(input logic v, input logic [7:0] b, input logic l, output logic took);
    byte_in_valid = v;
    byte_in       = b;
    byte_in_last  = l;
    if (stall_cnt > 0) begin
      block_out_ready = 1'b0;
      stall_cnt--;
    end else begin
      block_out_ready = ($urandom_range(0, 99) < ready_pct);
    end
    #1;
    if (held_vld) begin
      check("hold_valid", 64'(block_out_valid), 64'd1);
      check("hold_block", 64'(block_out), 64'(held_blk));
      check("hold_last", 64'(block_out_last), 64'(held_last));
    end
    held_vld = 1'b0;
    if (block_out_valid && !block_out_ready) begin
      check("stall_in_ready", 64'(byte_in_ready), 64'd0);
      held_vld  = 1'b1;
      held_blk  = block_out;
      held_last = block_out_last;
    end
    if (!block_out_valid)
      check("idle_in_ready", 64'(byte_in_ready), 64'd1);
    if (block_out_valid && block_out_ready) begin
      if (exp_blk_q.size() == 0) begin
        check("spurious_block", 64'(block_out_valid), 64'd0);
      end else begin
        check("block_data", 64'(block_out), 64'(exp_blk_q.pop_front()));
        check("block_last", 64'(block_out_last), 64'(exp_last_q.pop_front()));
      end
      m_blocks++;
    end
    took = v && byte_in_ready;
    if (took) model_accept(b, l);
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic l);
    logic took = 1'b0;
    for (int i = 0; i < 200 && !took; i++) cycle(1'b1, b, l, took);
    if (!took) check("send_timeout", 64'(took), 64'd1);
  endtask

  task automatic idle(input int n);
    logic took;
    for (int i = 0; i < n; i++) cycle(1'b0, 8'($urandom), 1'($urandom), took);
  endtask

  task automatic drain();
    logic took;
    ready_pct = 100;
    for (int i = 0; i < 100 && (exp_blk_q.size() != 0 || block_out_valid); i++)
      cycle(1'b0, 8'h00, 1'b0, took);
    check("drain_queue", 64'(exp_blk_q.size()), 64'd0);
    check("drain_valid", 64'(block_out_valid), 64'd0);
  endtask

  task automatic check_counters();
`ifdef BLOCK_PACKER_STATS_EN
    check("bytes_accepted", 64'(bytes_accepted), 64'(32'(m_bytes)));
    check("blocks_emitted", 64'(blocks_emitted), 64'(32'(m_blocks)));
    check("pad_bytes", 64'(pad_bytes), 64'(32'(m_pads)));
`else
    check("bytes_accepted_off", 64'(bytes_accepted), 64'd0);
    check("blocks_emitted_off", 64'(blocks_emitted), 64'd0);
    check("pad_bytes_off", 64'(pad_bytes), 64'd0);
`endif
  endtask

  task automatic do_reset();
    byte_in_valid   = 1'b0;
    byte_in_last    = 1'b0;
    block_out_ready = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_valid", 64'(block_out_valid), 64'd0);
    check("rst_block", 64'(block_out), 64'd0);
    check("rst_last", 64'(block_out_last), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    cur_q.delete();
    exp_blk_q.delete();
    exp_last_q.delete();
    m_bytes = 0;
    m_blocks = 0;
    m_pads = 0;
    held_vld = 1'b0;
    stall_cnt = 0;
    #1;
    check("rst_in_ready", 64'(byte_in_ready), 64'd1);
    check_counters();
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] msg[$];
    int len;
    rst = 1'b1;
    byte_in = 8'h00;
    byte_in_valid = 1'b0;
    byte_in_last = 1'b0;
    block_out_ready = 1'b0;
    @(negedge clk);
    do_reset();

    // Full block with last on the fourth byte; exact one-cycle latency.
    ready_pct = 100;
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    check("partial_hidden_valid", 64'(block_out_valid), 64'd0);
    check("partial_hidden_block", 64'(block_out), 64'd0);
    send_byte(8'h44, 1'b1);
    check("full_latency_valid", 64'(block_out_valid), 64'd1);
    check("full_block", 64'(block_out), 64'h11223344);
    check("full_last", 64'(block_out_last), 64'd1);
    drain();
    check_counters();

    // Single byte with last: three pad lanes of value 3.
    send_byte(8'hAA, 1'b1);
    check("pad3_block", 64'(block_out), 64'hAA030303);
    check("pad3_last", 64'(block_out_last), 64'd1);
    drain();
    check_counters();

    // Six-byte message: one full block then one padded block.
    do_reset();
    for (int i = 1; i <= 6; i++) send_byte(8'(i * 8'h11), i == 6);
    check("six_tail_block", 64'(block_out), 64'h55660202);
    drain();
    check("six_blocks", 64'(m_blocks), 64'd2);
    check_counters();

    // Reset mid-block discards the partial block.
    do_reset();
    send_byte(8'hE1, 1'b0);
    send_byte(8'hE2, 1'b0);
    send_byte(8'hE3, 1'b0);
    do_reset();
    for (int i = 1; i <= 4; i++) send_byte(8'(i), i == 4);
    check("post_rst_block", 64'(block_out), 64'h01020304);
    drain();
    check("post_rst_blocks", 64'(m_blocks), 64'd1);
    check_counters();

    // 1000-byte stream with a 20-cycle downstream stall in the middle.
    do_reset();
    ready_pct = 100;
    for (int i = 0; i < 1000; i++) begin
      if (i == 500) stall_cnt = 20;
      send_byte(8'($urandom), i == 999);
    end
    drain();
    check("stream_blocks", 64'(m_blocks), 64'd250);
    check("stream_bytes", 64'(m_bytes), 64'd1000);
    check_counters();

    // Random messages, random lengths, random downstream readiness and gaps.
    for (int m = 0; m < 40; m++) begin
      ready_pct = $urandom_range(30, 100);
      len = $urandom_range(1, 9);
      for (int i = 0; i < len; i++) send_byte(8'($urandom), i == len - 1);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 4));
    end
    drain();
    check_counters();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
